fetch_controller: RTL and testbench
===================================

# fetch_controller

Sequences the instruction-fetch stage of the 5-stage pipeline. Owns the program counter and drives the byte address into the combinational instruction memory. Latches the returned 32-bit word into the IF/ID register. Applies hazard-unit stalls and branch redirects from the EX/MEM stage, and halts fetch cleanly once the PC runs off the end of the program image.

## Interface
Parameters:
- RESET_PC, 64'd0, PC value loaded on reset
- MEM_BYTES, 32, instruction memory size in bytes (multiple of 4)

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- stall  input  1  hazard-unit stall; holds PC and IF/ID contents
- branch_taken  input  1  EX/MEM resolved taken branch; single-cycle pulse
- branch_target  input  64  byte address of branch destination
- Inst_Address  output  64  byte address to instruction memory; always equals pc
- Instruction  input  32  word returned combinationally by instruction memory
- if_id_pc  output  64  PC of instruction held in IF/ID
- if_id_instr  output  32  instruction held in IF/ID
- if_id_valid  output  1  IF/ID holds a real instruction; 0 = bubble
- halted  output  1  fetch stopped at end of image
- fetch_err  output  1  sticky misaligned/out-of-range target flag (FETCH_BOUND_CHECK_EN only; tied 0 otherwise)
- fetch_count  output  32  number of instructions issued into IF/ID

## Operation
- States: BOOT, RUN, HALT.
- Reset, evaluated every edge with highest priority:
  - State = BOOT, pc = RESET_PC.
  - if_id_pc = 0, if_id_instr = 0 (instr reads as nop `add x0,x0,x0` once decoded as bubble), if_id_valid = 0.
  - halted = 0, fetch_err = 0, fetch_count = 0.
- BOOT: one cycle with if_id_valid = 0 and pc unchanged; next state RUN.
- RUN, in priority order:
  - branch_taken: pc <= branch_target; if_id_valid <= 0 (flushes the wrong-path word); branch wins over stall.
  - stall: pc, IF/ID and fetch_count hold.
  - Otherwise: if_id_pc <= pc, if_id_instr <= Instruction, if_id_valid <= 1, fetch_count += 1, pc <= pc + 4.
  - If pc + 4 == MEM_BYTES on an issuing cycle, next state is HALT.
- HALT:
  - halted = 1, if_id_valid <= 0 and pc frozen, but only when stall = 0. While stalled, the last word stays valid in IF/ID.
  - branch_taken: pc <= branch_target, halted <= 0, next state RUN. This handles branches still draining in the pipeline.
- Arithmetic: pc + 4 is 64-bit and wraps modulo 2^64. fetch_count saturates at 32'hFFFF_FFFF.

## Timing
- Inst_Address is combinational from the pc register. Instruction is sampled at the same edge, giving one-cycle fetch latency into IF/ID.
- Branch penalty: one bubble cycle in IF/ID after the branch_taken edge. The target's word appears with if_id_valid = 1 on the next edge.
- branch_taken and stall in the same cycle: the redirect is taken, and IF/ID becomes a bubble (not held).
- First valid instruction appears at edge 2 after reset deasserts (BOOT, then RUN).

## Configuration
- FETCH_BOUND_CHECK_EN defined: a branch_target that is not 4-byte aligned or is >= MEM_BYTES sets sticky fetch_err, forces HALT, and does not load pc. The same check applies on reset if RESET_PC is invalid. fetch_err clears only on reset.
- Undefined: no checks. Inst_Address simply follows pc, and fetch_err is tied 0.

## Structure
- Shared package (cpu_pkg) holds the state encodings (BOOT=2'd0, RUN=2'd1, HALT=2'd2), the NOP constant 32'h0000_0033, and the INSTR_BYTES=4 constant.
- One natural sub-module: pc_reg, the pc register with next-pc mux (reset / target / +4 / hold).
- The controller FSM, IF/ID register and counter stay in fetch_controller.

## Test plan
- Reset, then 8 free-running cycles with MEM_BYTES=32 → if_id_pc 0,4,…,28, all valid; halted=1 after pc 28 issues; fetch_count=8.
- stall high for 3 cycles at pc=8 → IF/ID holds pc 4's word for 3 cycles; pc stays 8; fetch_count unchanged.
- branch_taken with target 16, asserted while pc=12 → next IF/ID is a bubble, then if_id_pc=16 valid. Word at 12 is never issued.
- stall and branch_taken together, target 0 → pc=0, if_id_valid=0 on that edge.
- In HALT, branch_taken with target 4 → halted drops, if_id_pc=4 valid one cycle later.
- With FETCH_BOUND_CHECK_EN, branch_target 6, then separately 40 → fetch_err=1, HALT, pc unchanged; reset clears fetch_err.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch-stage encodings and constants
package cpu_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  // add x0,x0,x0
  localparam logic [31:0] NOP         = 32'h0000_0033;
  localparam int          INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_controller_pc_reg.sv
// rtl/fetch_controller_pc_reg.sv - program counter register with next-pc mux
module pc_reg
  import cpu_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_target,
  input  logic [63:0] target,
  input  logic        advance,
  output logic [63:0] pc
);

  // Next-pc mux: reset, redirect, sequential advance (wraps mod 2^64), else hold
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (load_target) begin
      pc <= target;
    end else if (advance) begin
      pc <= pc + 64'(INSTR_BYTES);
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - IF-stage sequencer; optional FETCH_BOUND_CHECK_EN adds target checks
module fetch_controller
  import cpu_pkg::*;
#(
  parameter logic [63:0] RESET_PC  = 64'd0,
  parameter int          MEM_BYTES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  output logic [63:0] Inst_Address,
  input  logic [31:0] Instruction,
  output logic [63:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        halted,
  output logic        fetch_err,
  output logic [31:0] fetch_count
);

  fetch_state_e state, next_state;
  logic [63:0]  pc;
  logic         at_end;
  logic         target_bad;
  logic         reset_bad;

  // control strobes from the output decode
  logic pc_load, pc_advance, issue, flush, halt_set, halt_clr, err_set;

`ifdef FETCH_BOUND_CHECK_EN
  function automatic logic addr_bad(input logic [63:0] a);
    return (a[1:0] != 2'b00) || (a >= 64'(MEM_BYTES));
  endfunction
  assign target_bad = addr_bad(branch_target);
  assign reset_bad  = addr_bad(RESET_PC);
`else
  assign target_bad = 1'b0;
  assign reset_bad  = 1'b0;
`endif

  assign Inst_Address = pc;
  assign at_end       = (pc + 64'(INSTR_BYTES)) == 64'(MEM_BYTES);

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk         (clk),
    .reset       (reset),
    .load_target (pc_load),
    .target      (branch_target),
    .advance     (pc_advance),
    .pc          (pc)
  );

  // State register; an invalid reset pc parks the fetch in HALT
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= reset_bad ? HALT : BOOT;
    end else begin
      state <= next_state;
    end
  end

  // Next-state: boot lasts one cycle, end of image halts, good branch resumes
  always_comb begin
    next_state = state;
    case (state)
      BOOT: next_state = RUN;
      RUN: begin
        if (branch_taken) begin
          next_state = target_bad ? HALT : RUN;
        end else if (!stall && at_end) begin
          next_state = HALT;
        end
      end
      HALT: begin
        if (branch_taken && !target_bad) begin
          next_state = RUN;
        end
      end
      default: next_state = BOOT;
    endcase
  end

  // Output decode: branch beats stall; stall freezes everything else
  always_comb begin
    pc_load    = 1'b0;
    pc_advance = 1'b0;
    issue      = 1'b0;
    flush      = 1'b0;
    halt_set   = 1'b0;
    halt_clr   = 1'b0;
    err_set    = 1'b0;
    case (state)
      RUN: begin
        if (branch_taken) begin
          flush = 1'b1;
          if (target_bad) begin
            err_set  = 1'b1;
            halt_set = 1'b1;
          end else begin
            pc_load = 1'b1;
          end
        end else if (!stall) begin
          issue      = 1'b1;
          pc_advance = 1'b1;
        end
      end
      HALT: begin
        if (branch_taken) begin
          flush = 1'b1;
          if (target_bad) begin
            err_set = 1'b1;
          end else begin
            pc_load  = 1'b1;
            halt_clr = 1'b1;
          end
        end else if (!stall) begin
          flush    = 1'b1;
          halt_set = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // IF/ID register, halted flag and saturating issue counter
  always_ff @(posedge clk) begin
    if (reset) begin
      if_id_pc    <= 64'd0;
      if_id_instr <= 32'd0;
      if_id_valid <= 1'b0;
      halted      <= reset_bad;
      fetch_count <= 32'd0;
    end else begin
      if (issue) begin
        if_id_pc    <= pc;
        if_id_instr <= Instruction;
        if_id_valid <= 1'b1;
        if (fetch_count != 32'hFFFF_FFFF) begin
          fetch_count <= fetch_count + 32'd1;
        end
      end else if (flush) begin
        if_id_valid <= 1'b0;
      end
      if (halt_set) begin
        halted <= 1'b1;
      end else if (halt_clr) begin
        halted <= 1'b0;
      end
    end
  end

`ifdef FETCH_BOUND_CHECK_EN
  // Sticky error, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_err <= reset_bad;
    end else if (err_set) begin
      fetch_err <= 1'b1;
    end
  end
`else
  assign fetch_err = 1'b0;
  logic unused_err;
  assign unused_err = err_set;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - randomized bench with behavioural fetch model
module tb_fetch_controller;
  localparam int MEM_BYTES = 32;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic [63:0] Inst_Address;
  logic [31:0] Instruction;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        halted;
  logic        fetch_err;
  logic [31:0] fetch_count;

  logic [31:0] mem [8];

  int n_pass  = 0;
  int n_total = 0;

  // model state
  logic [63:0] m_pc;
  logic        m_boot, m_stopped, m_v, m_halted, m_err;
  logic [63:0] m_ipc;
  logic [31:0] m_ins;
  logic [31:0] m_cnt;

  fetch_controller #(.RESET_PC(64'd0), .MEM_BYTES(MEM_BYTES)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .Inst_Address  (Inst_Address),
    .Instruction   (Instruction),
    .if_id_pc      (if_id_pc),
    .if_id_instr   (if_id_instr),
    .if_id_valid   (if_id_valid),
    .halted        (halted),
    .fetch_err     (fetch_err),
    .fetch_count   (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a < 64'(MEM_BYTES) && a[1:0] == 2'b00) return mem[a[4:2]];
    return 32'hDEAD_BEEF;
  endfunction

  assign Instruction = mem_word(Inst_Address);

  function automatic logic bad_target(input logic [63:0] a);
`ifdef FETCH_BOUND_CHECK_EN
    return (a[1:0] != 2'b00) || (a >= 64'(MEM_BYTES));
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // model of one rising edge, from the fetch rules
  task automatic model_edge(input logic r, input logic s, input logic b, input logic [63:0] t);
    if (r) begin
      m_pc = 64'd0; m_boot = 1; m_stopped = 0; m_v = 0; m_halted = 0;
      m_err = 0; m_ipc = 0; m_ins = 0; m_cnt = 0;
    end else if (m_boot) begin
      m_boot = 0;
    end else if (!m_stopped) begin
      if (b) begin
        m_v = 0;
        if (bad_target(t)) begin
          m_err = 1; m_stopped = 1; m_halted = 1;
        end else begin
          m_pc = t;
        end
      end else if (!s) begin
        m_ipc = m_pc;
        m_ins = mem_word(m_pc);
        m_v   = 1;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        if (m_pc + 64'd4 == 64'(MEM_BYTES)) m_stopped = 1;
        m_pc = m_pc + 64'd4;
      end
    end else begin
      if (b) begin
        m_v = 0;
        if (bad_target(t)) begin
          m_err = 1;
        end else begin
          m_pc = t; m_halted = 0; m_stopped = 0;
        end
      end else if (!s) begin
        m_halted = 1; m_v = 0;
      end
    end
  endtask

  task automatic compare_all();
    chk("Inst_Address", Inst_Address, m_pc);
    chk("if_id_valid", 64'(if_id_valid), 64'(m_v));
    if (m_v) begin
      chk("if_id_pc", if_id_pc, m_ipc);
      chk("if_id_instr", 64'(if_id_instr), 64'(m_ins));
    end
    chk("halted", 64'(halted), 64'(m_halted));
    chk("fetch_err", 64'(fetch_err), 64'(m_err));
    chk("fetch_count", 64'(fetch_count), 64'(m_cnt));
  endtask

  // drive one cycle, advance the model on the edge, check on the falling edge
  task automatic step(input logic r, input logic s, input logic b, input logic [63:0] t);
    reset = r; stall = s; branch_taken = b; branch_target = t;
    @(posedge clk);
    model_edge(r, s, b, t);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = $urandom;
    reset = 1; stall = 0; branch_taken = 0; branch_target = 0;

    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("rst_pc", Inst_Address, 64'd0);
    chk("rst_valid", 64'(if_id_valid), 64'd0);
    chk("rst_count", 64'(fetch_count), 64'd0);
    chk("rst_instr", 64'(if_id_instr), 64'd0);

    step(0, 0, 0, 0);
    chk("boot_valid", 64'(if_id_valid), 64'd0);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 0);
      chk("run_pc", if_id_pc, 64'(i * 4));
      chk("run_valid", 64'(if_id_valid), 64'd1);
      chk("run_instr", 64'(if_id_instr), 64'(mem[i]));
    end
    chk("count8", 64'(fetch_count), 64'd8);
    step(0, 0, 0, 0);
    chk("halted_end", 64'(halted), 64'd1);
    chk("halt_bubble", 64'(if_id_valid), 64'd0);

    step(0, 0, 1, 64'd4);
    chk("resume_halted", 64'(halted), 64'd0);
    chk("resume_pc", Inst_Address, 64'd4);
    step(0, 0, 0, 0);
    chk("resume_issue", if_id_pc, 64'd4);
    chk("resume_valid", 64'(if_id_valid), 64'd1);

    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0);
      chk("stall_ifid", if_id_pc, 64'd4);
      chk("stall_pc", Inst_Address, 64'd8);
      chk("stall_count", 64'(fetch_count), 64'd9);
    end
    step(0, 0, 0, 0);
    step(0, 0, 1, 64'd16);
    chk("br_bubble", 64'(if_id_valid), 64'd0);
    step(0, 0, 0, 0);
    chk("br_target_pc", if_id_pc, 64'd16);
    chk("br_target_valid", 64'(if_id_valid), 64'd1);
    chk("br_count", 64'(fetch_count), 64'd11);

    step(0, 1, 1, 64'd0);
    chk("brstall_pc", Inst_Address, 64'd0);
    chk("brstall_valid", 64'(if_id_valid), 64'd0);

`ifdef FETCH_BOUND_CHECK_EN
    step(0, 0, 1, 64'd6);
    chk("err_misalign", 64'(fetch_err), 64'd1);
    chk("err_pc_hold", Inst_Address, 64'd0);
    step(0, 0, 0, 0);
    chk("err_halted", 64'(halted), 64'd1);
    step(1, 0, 0, 0);
    chk("err_cleared", 64'(fetch_err), 64'd0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 64'd40);
    chk("err_range", 64'(fetch_err), 64'd1);
    chk("err_range_pc", Inst_Address, 64'd0);
    step(1, 0, 0, 0);
`endif

    for (int n = 0; n < 3000; n++) begin
      logic        r, s, b;
      logic [63:0] t;
      r = ($urandom_range(0, 99) < 1);
      s = ($urandom_range(0, 99) < 25);
      b = ($urandom_range(0, 99) < 15);
      t = 64'($urandom_range(0, 7) * 4);
`ifdef FETCH_BOUND_CHECK_EN
      if ($urandom_range(0, 9) == 0) t = ($urandom_range(0, 1) == 0) ? 64'd6 : 64'd40;
`endif
      step(r, s, b, t);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
